// File: rtl/nibble_sum_accumulator.sv
// Sums NUM_TERMS 5-bit adder results {Cout,Sum} into a saturating ACC_WIDTH-bit total
// and hands each completed total to the activation stage over valid/ready.
module nibble_sum_accumulator #(
  parameter int ACC_WIDTH = 12,
  parameter int NUM_TERMS = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           Sum,
  input  logic                 Cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(NUM_TERMS - 1);

  logic [0:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 sticky_q, sticky_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH-1:0] acc_sat;
  logic                 sat;
  logic                 sticky_new;

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;

  // One extra bit of headroom: its carry is exactly the "exceeds all-ones" condition.
  assign acc_sum    = {1'b0, acc_q} + {{(ACC_WIDTH-4){1'b0}}, Cout, Sum};
  assign sat        = acc_sum[ACC_WIDTH];
  assign acc_sat    = sat ? '1 : acc_sum[ACC_WIDTH-1:0];
  assign sticky_new = sticky_q | sat;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    if (clear) begin
      // Abort wins over any handshake; the last result value is intentionally kept.
      state_d  = ST_ACCUM;
      acc_d    = '0;
      count_d  = '0;
      sticky_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid) begin
            if (count_q == LAST_COUNT) begin
              result_d = acc_sat;
              ovf_d    = sticky_new;
              acc_d    = '0;
              count_d  = '0;
              sticky_d = 1'b0;
              state_d  = ST_DONE;
            end else begin
              acc_d    = acc_sat;
              count_d  = count_q + 1'b1;
              sticky_d = sticky_new;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_ACCUM;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ACCUM;
      acc_q    <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_nibble_sum_accumulator.sv
// Drives a 12-bit and an 8-bit accumulator with one shared term stream and checks
// both against a saturating-sum reference model.
module tb_nibble_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  Sum = 4'd0;
  logic        Cout = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, overflow_a;
  logic [11:0] result_a;
  logic        in_ready_b, out_valid_b, overflow_b;
  logic [7:0]  result_b;

  int n_checks = 0;
  int n_fails  = 0;
  int model_terms[$];

  always #5 clk = ~clk;

  nibble_sum_accumulator dut_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
    .Sum(Sum), .Cout(Cout), .out_valid(out_valid_a), .out_ready(out_ready),
    .result(result_a), .overflow(overflow_a)
  );

  nibble_sum_accumulator #(.ACC_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .Sum(Sum), .Cout(Cout), .out_valid(out_valid_b), .out_ready(out_ready),
    .result(result_b), .overflow(overflow_b)
  );

  // Reference: the saturating total is the true sum clipped to the all-ones value.
  function automatic int model_total();
    int tot = 0;
    foreach (model_terms[i]) tot += model_terms[i];
    return tot;
  endfunction

  function automatic int model_result(input int width);
    int maxv = (1 << width) - 1;
    return (model_total() > maxv) ? maxv : model_total();
  endfunction

  function automatic int model_ovf(input int width);
    return (model_total() > ((1 << width) - 1)) ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_term(input int t);
    int w = 0;
    {Cout, Sum} = 5'(t);
    in_valid = 1'b1;
    while (in_ready_a !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    if (w >= 100) check("in_ready_timeout", in_ready_a, 1);
    step();
    in_valid = 1'b0;
    model_terms.push_back(t);
  endtask

  // mode: 0 = constant value, 1 = ascending index, 2 = random 0..31
  task automatic send_batch(input int mode, input int value, input int max_gap);
    int t;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          step();
          check("bubble_in_ready", in_ready_a, 1);
        end
      end
      t = (mode == 0) ? value : (mode == 1) ? i : int'($urandom_range(0, 31));
      send_term(t);
    end
    check("latency_out_valid", out_valid_a, 1);
  endtask

  task automatic expect_result(input int hold_cycles);
    int w = 0;
    logic [11:0] held;
    while (out_valid_a !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    if (w >= 100) check("out_valid_timeout", out_valid_a, 1);
    check("result_a", result_a, model_result(12));
    check("overflow_a", overflow_a, model_ovf(12));
    check("result_b", result_b, model_result(8));
    check("overflow_b", overflow_b, model_ovf(8));
    check("out_valid_b", out_valid_b, 1);
    $display("batch total=%0d result_a=%0d result_b=%0d overflow_b=%0d",
             model_total(), result_a, result_b, overflow_b);
    held = result_a;
    if (hold_cycles > 0) begin
      {Cout, Sum} = 5'd7;
      in_valid = 1'b1;
    end
    repeat (hold_cycles) begin
      step();
      check("hold_out_valid", out_valid_a, 1);
      check("hold_result", result_a, held);
      check("hold_in_ready", in_ready_a, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_hs_out_valid", out_valid_a, 0);
    check("post_hs_in_ready", in_ready_a, 1);
    model_terms.delete();
  endtask

  initial begin
    logic [11:0] last_a;
    step();
    step();
    check("rst_result", result_a, 0);
    check("rst_overflow", overflow_a, 0);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    check("rst_in_ready_b", in_ready_b, 1);
    rst = 1'b0;

    // Full-scale terms: 496 in 12 bits, saturates in 8 bits.
    send_batch(0, 31, 0);
    expect_result(0);
    // Sticky flag must not leak into the next batch.
    send_batch(0, 1, 0);
    expect_result(0);
    // Ascending terms with bubbles.
    send_batch(1, 0, 3);
    expect_result(0);
    // Backpressure with a term offered while DONE.
    send_batch(2, 0, 1);
    expect_result(5);

    // clear after 7 terms, coincident with an offered term.
    last_a = result_a;
    for (int i = 0; i < 7; i++) send_term(3);
    {Cout, Sum} = 5'd9;
    in_valid = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear_out_valid", out_valid_a, 0);
    check("clear_in_ready", in_ready_a, 1);
    check("clear_overflow", overflow_a, 0);
    check("clear_result_kept", result_a, last_a);
    model_terms.delete();
    send_batch(0, 2, 0);
    expect_result(0);

    // clear while a result is pending.
    send_batch(0, 31, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_done_out_valid", out_valid_a, 0);
    check("clear_done_result_kept", result_a, 496);
    check("clear_done_overflow_b", overflow_b, 0);
    model_terms.delete();

    // Reset mid-batch.
    for (int i = 0; i < 5; i++) send_term(int'($urandom_range(0, 31)));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_out_valid", out_valid_a, 0);
    check("rst_mid_in_ready", in_ready_a, 1);
    check("rst_mid_result", result_a, 0);
    model_terms.delete();
    send_batch(2, 0, 2);
    expect_result(0);

    // Reset while DONE.
    send_batch(2, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_done_out_valid", out_valid_a, 0);
    check("rst_done_in_ready", in_ready_a, 1);
    model_terms.delete();

    for (int b = 0; b < 4; b++) begin
      send_batch(2, 0, 2);
      expect_result(int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
